// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab 3 command parser.
// States, modes, ASCII codes and the per-position digit limits live here.
package lab3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIG0,
    DIG1,
    DIG2,
    DIG3,
    WAIT_CR
  } state_t;

  typedef enum logic {
    MODE_TIME,
    MODE_ALARM
  } mode_t;

  localparam logic [7:0] ASCII_L    = 8'h6c;
  localparam logic [7:0] ASCII_A    = 8'h61;
  localparam logic [7:0] ASCII_AT   = 8'h40;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0d;
  localparam logic [7:0] ASCII_ESC  = 8'h1b;

  // Positions are ordered Mtens, Mones, Stens, Sones (MM:SS).
  localparam logic [3:0] LIMIT_MTENS = 4'd5;
  localparam logic [3:0] LIMIT_MONES = 4'd9;
  localparam logic [3:0] LIMIT_STENS = 4'd5;
  localparam logic [3:0] LIMIT_SONES = 4'd9;

  function automatic logic [3:0] digit_limit(input logic [1:0] pos);
    logic [3:0] lim;
    case (pos)
      2'd0:    lim = LIMIT_MTENS;
      2'd1:    lim = LIMIT_MONES;
      2'd2:    lim = LIMIT_STENS;
      default: lim = LIMIT_SONES;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/lab3_cmd_parser_if.sv
// Byte-stream link between the UART and the command parser.
// master = UART side (drives received bytes), slave = parser side (drives echo bytes).
interface lab3_cmd_parser_if;

  logic [7:0] rx_data;
  logic       rx_data_rdy;
  logic [7:0] tx_data;
  logic       tx_data_rdy;

  modport master (
    output rx_data,
    output rx_data_rdy,
    input  tx_data,
    input  tx_data_rdy
  );

  modport slave (
    input  rx_data,
    input  rx_data_rdy,
    output tx_data,
    output tx_data_rdy
  );

endinterface

// File: rtl/lab3_cmd_parser_ascii_digit_chk.sv
// Combinational ASCII digit checker: converts a byte to BCD and flags whether
// it is a decimal digit no larger than the supplied limit.
module ascii_digit_chk
  import lab3_pkg::*;
(
  input  logic [7:0] ascii_byte,
  input  logic [3:0] limit,
  output logic [3:0] bcd,
  output logic       valid
);

  logic [7:0] offset;

  // Bytes below '0' wrap to large offsets, so the lower-bound test is explicit.
  always_comb begin
    offset = ascii_byte - ASCII_ZERO;
    bcd    = offset[3:0];
    valid  = (ascii_byte >= ASCII_ZERO) && (offset <= {4'd0, limit});
  end

endmodule

// File: rtl/lab3_cmd_parser.sv
// Command parser for the lab 3 clock/alarm: decodes 'l'/'a' + MMSS + CR and '@'.
// Define LAB3_CMD_ECHO_EN to build the echo path toward the UART transmitter.
module lab3_cmd_parser
  import lab3_pkg::*;
#(
  parameter logic [7:0] CR_CODE  = ASCII_CR,
  parameter logic [7:0] ESC_CODE = ASCII_ESC
) (
  input  logic              clk12m,
  input  logic              rst_n,
  lab3_cmd_parser_if.slave  uart,
  output logic [3:0]        time_mtens,
  output logic [3:0]        time_mones,
  output logic [3:0]        time_stens,
  output logic [3:0]        time_sones,
  output logic              ld_time,
  output logic [3:0]        alarm_mtens,
  output logic [3:0]        alarm_mones,
  output logic [3:0]        alarm_stens,
  output logic [3:0]        alarm_sones,
  output logic              ld_alarm,
  output logic              alarm_en,
  output logic              cmd_err
);

  state_t          state_q, state_d;
  mode_t           mode_q, mode_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0][3:0] time_q, alarm_q;
  logic            commit_time, commit_alarm;
  logic            err_d, toggle_en;
  logic            is_restart;
  logic [1:0]      dig_pos;
  logic [3:0]      dig_limit;
  logic [3:0]      dig_bcd;
  logic            dig_valid;

  always_comb begin
    dig_pos = 2'd0;
    case (state_q)
      DIG1:    dig_pos = 2'd1;
      DIG2:    dig_pos = 2'd2;
      DIG3:    dig_pos = 2'd3;
      default: dig_pos = 2'd0;
    endcase
  end

  assign dig_limit  = digit_limit(dig_pos);
  assign is_restart = (uart.rx_data == ASCII_L) || (uart.rx_data == ASCII_A);

  ascii_digit_chk u_digit_chk (
    .ascii_byte (uart.rx_data),
    .limit      (dig_limit),
    .bcd        (dig_bcd),
    .valid      (dig_valid)
  );

  // Restart beats abort beats digit/CR handling in every capture state.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    shadow_d     = shadow_q;
    commit_time  = 1'b0;
    commit_alarm = 1'b0;
    err_d        = 1'b0;
    toggle_en    = 1'b0;
    if (uart.rx_data_rdy) begin
      if (state_q == IDLE) begin
        if (uart.rx_data == ASCII_L) begin
          state_d = DIG0;
          mode_d  = MODE_TIME;
        end else if (uart.rx_data == ASCII_A) begin
          state_d = DIG0;
          mode_d  = MODE_ALARM;
        end else if (uart.rx_data == ASCII_AT) begin
          toggle_en = 1'b1;
        end
      end else if (is_restart) begin
        state_d = DIG0;
        mode_d  = (uart.rx_data == ASCII_L) ? MODE_TIME : MODE_ALARM;
      end else if (uart.rx_data == ESC_CODE) begin
        state_d = IDLE;
      end else if (state_q == WAIT_CR) begin
        state_d = IDLE;
        if (uart.rx_data == CR_CODE) begin
          commit_time  = (mode_q == MODE_TIME);
          commit_alarm = (mode_q == MODE_ALARM);
        end else begin
          err_d = 1'b1;
        end
      end else if (dig_valid) begin
        shadow_d[dig_pos] = dig_bcd;
        case (state_q)
          DIG0:    state_d = DIG1;
          DIG1:    state_d = DIG2;
          DIG2:    state_d = DIG3;
          default: state_d = WAIT_CR;
        endcase
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_TIME;
      shadow_q <= '0;
      time_q   <= '0;
      alarm_q  <= '0;
      ld_time  <= 1'b0;
      ld_alarm <= 1'b0;
      alarm_en <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      ld_time  <= commit_time;
      ld_alarm <= commit_alarm;
      cmd_err  <= err_d;
      if (commit_time) begin
        time_q <= shadow_q;
      end
      if (commit_alarm) begin
        alarm_q <= shadow_q;
      end
      if (toggle_en) begin
        alarm_en <= ~alarm_en;
      end
    end
  end

  assign time_mtens  = time_q[0];
  assign time_mones  = time_q[1];
  assign time_stens  = time_q[2];
  assign time_sones  = time_q[3];
  assign alarm_mtens = alarm_q[0];
  assign alarm_mones = alarm_q[1];
  assign alarm_stens = alarm_q[2];
  assign alarm_sones = alarm_q[3];

`ifdef LAB3_CMD_ECHO_EN
  logic       echo;
  logic [7:0] tx_data_q;
  logic       tx_data_rdy_q;

  // Outside IDLE every strobed byte is either accepted or an error;
  // in IDLE only 'l', 'a' and '@' count as accepted.
  assign echo = uart.rx_data_rdy && !err_d &&
                ((state_q != IDLE) || (state_d != IDLE) || toggle_en);

  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q     <= 8'h00;
      tx_data_rdy_q <= 1'b0;
    end else begin
      tx_data_rdy_q <= echo;
      if (echo) begin
        tx_data_q <= uart.rx_data;
      end
    end
  end

  assign uart.tx_data     = tx_data_q;
  assign uart.tx_data_rdy = tx_data_rdy_q;
`else
  assign uart.tx_data     = 8'h00;
  assign uart.tx_data_rdy = 1'b0;
`endif

endmodule

// File: tb/tb_lab3_cmd_parser.sv
// Table-driven bench for lab3_cmd_parser with a scoreboard queue of expected outputs.
// Build with LAB3_CMD_ECHO_EN defined to also check the echo path.
module tb_lab3_cmd_parser;
  import lab3_pkg::*;

  typedef struct {
    logic        rdy;
    logic [7:0]  data;
    logic        echo;
    logic        ld_time;
    logic        ld_alarm;
    logic        cmd_err;
    logic        alarm_en;
    logic [15:0] time_bcd;
    logic [15:0] alarm_bcd;
  } vec_t;

  logic clk12m = 1'b0;
  logic rst_n  = 1'b0;

  lab3_cmd_parser_if uart ();

  logic [3:0] time_mtens, time_mones, time_stens, time_sones;
  logic [3:0] alarm_mtens, alarm_mones, alarm_stens, alarm_sones;
  logic       ld_time, ld_alarm, alarm_en, cmd_err;

  int total   = 0;
  int bad     = 0;
  int vec_idx = 0;

  vec_t vecs[$];
  vec_t sb[$];

  logic [15:0] t_exp;
  logic [15:0] a_exp;
  logic        en_exp;

  always #42 clk12m = ~clk12m;

  lab3_cmd_parser dut (
    .clk12m      (clk12m),
    .rst_n       (rst_n),
    .uart        (uart),
    .time_mtens  (time_mtens),
    .time_mones  (time_mones),
    .time_stens  (time_stens),
    .time_sones  (time_sones),
    .ld_time     (ld_time),
    .alarm_mtens (alarm_mtens),
    .alarm_mones (alarm_mones),
    .alarm_stens (alarm_stens),
    .alarm_sones (alarm_sones),
    .ld_alarm    (ld_alarm),
    .alarm_en    (alarm_en),
    .cmd_err     (cmd_err)
  );

  function automatic void addVec(input logic [7:0] data, input logic echo,
                                 input logic ldt, input logic lda, input logic err);
    vec_t v;
    v.rdy       = 1'b1;
    v.data      = data;
    v.echo      = echo;
    v.ld_time   = ldt;
    v.ld_alarm  = lda;
    v.cmd_err   = err;
    v.alarm_en  = en_exp;
    v.time_bcd  = t_exp;
    v.alarm_bcd = a_exp;
    vecs.push_back(v);
  endfunction

  function automatic void addIdle();
    vec_t v;
    v.rdy       = 1'b0;
    v.data      = 8'h00;
    v.echo      = 1'b0;
    v.ld_time   = 1'b0;
    v.ld_alarm  = 1'b0;
    v.cmd_err   = 1'b0;
    v.alarm_en  = en_exp;
    v.time_bcd  = t_exp;
    v.alarm_bcd = a_exp;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, req);
    end
  endtask

  task automatic checkOutput(input vec_t e, input int idx);
    cmp("flags", idx, {28'd0, ld_time, ld_alarm, cmd_err, alarm_en},
        {28'd0, e.ld_time, e.ld_alarm, e.cmd_err, e.alarm_en});
    cmp("time", idx, {16'd0, time_mtens, time_mones, time_stens, time_sones},
        {16'd0, e.time_bcd});
    cmp("alarm", idx, {16'd0, alarm_mtens, alarm_mones, alarm_stens, alarm_sones},
        {16'd0, e.alarm_bcd});
`ifdef LAB3_CMD_ECHO_EN
    cmp("tx_rdy", idx, {31'd0, uart.tx_data_rdy}, {31'd0, e.echo});
    if (e.echo) begin
      cmp("tx_data", idx, {24'd0, uart.tx_data}, {24'd0, e.data});
    end
`else
    cmp("tx_rdy", idx, {31'd0, uart.tx_data_rdy}, 32'd0);
    cmp("tx_data", idx, {24'd0, uart.tx_data}, 32'd0);
`endif
  endtask

  task automatic checkReset(input string name);
    cmp({name, "_flags"}, vec_idx,
        {27'd0, ld_time, ld_alarm, cmd_err, alarm_en, uart.tx_data_rdy}, 32'd0);
    cmp({name, "_digits"}, vec_idx,
        {time_mtens, time_mones, time_stens, time_sones,
         alarm_mtens, alarm_mones, alarm_stens, alarm_sones}, 32'd0);
    cmp({name, "_tx_data"}, vec_idx, {24'd0, uart.tx_data}, 32'd0);
  endtask

  // Drives one table entry per cycle starting on a falling edge; results are
  // popped from the scoreboard on the next falling edge.
  task automatic applyStimulus();
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      uart.rx_data     = vecs[i].data;
      uart.rx_data_rdy = vecs[i].rdy;
      sb.push_back(vecs[i]);
      @(negedge clk12m);
      e = sb.pop_front();
      checkOutput(e, vec_idx);
      vec_idx++;
    end
    uart.rx_data     = 8'h00;
    uart.rx_data_rdy = 1'b0;
    vecs.delete();
  endtask

  task automatic sendByte(input logic [7:0] data);
    uart.rx_data     = data;
    uart.rx_data_rdy = 1'b1;
    @(negedge clk12m);
    uart.rx_data     = 8'h00;
    uart.rx_data_rdy = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    uart.rx_data     = 8'h00;
    uart.rx_data_rdy = 1'b0;
    t_exp  = 16'h0000;
    a_exp  = 16'h0000;
    en_exp = 1'b0;

    repeat (3) @(negedge clk12m);
    checkReset("por");
    rst_n = 1'b1;
    @(negedge clk12m);
    checkReset("post_reset");

    // load time 00:10
    addVec(ASCII_L, 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("1", 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    t_exp = 16'h0010;
    addVec(ASCII_CR, 1, 1, 0, 0);
    addIdle();
    // ignored 'n' bytes, then load alarm 03:24
    repeat (3) addVec("n", 0, 0, 0, 0);
    addVec(ASCII_A, 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("3", 1, 0, 0, 0);
    addVec("2", 1, 0, 0, 0);
    addVec("4", 1, 0, 0, 0);
    a_exp = 16'h0324;
    addVec(ASCII_CR, 1, 0, 1, 0);
    addIdle();
    // alarm enable toggle twice
    en_exp = 1'b1;
    addVec(ASCII_AT, 1, 0, 0, 0);
    addIdle();
    en_exp = 1'b0;
    addVec(ASCII_AT, 1, 0, 0, 0);
    addIdle();
    // out-of-range Mtens, then trailing bytes ignored in IDLE
    addVec(ASCII_L, 1, 0, 0, 0);
    addVec("7", 0, 0, 0, 1);
    addIdle();
    addVec("1", 0, 0, 0, 0);
    addVec(ASCII_CR, 0, 0, 0, 0);
    // restart from time to alarm mid-capture
    addVec(ASCII_L, 1, 0, 0, 0);
    addVec("1", 1, 0, 0, 0);
    addVec("2", 1, 0, 0, 0);
    addVec(ASCII_A, 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("5", 1, 0, 0, 0);
    a_exp = 16'h0005;
    addVec(ASCII_CR, 1, 0, 1, 0);
    // 'l' sampled while ld_alarm is high; upper-limit digits 59:59
    addVec(ASCII_L, 1, 0, 0, 0);
    addVec("5", 1, 0, 0, 0);
    addVec("9", 1, 0, 0, 0);
    addVec("5", 1, 0, 0, 0);
    addVec("9", 1, 0, 0, 0);
    t_exp = 16'h5959;
    addVec(ASCII_CR, 1, 1, 0, 0);
    addVec(ASCII_L, 1, 0, 0, 0);
    addVec("6", 0, 0, 0, 1);
    // non-digits just above '9' and just below '0'
    addVec(ASCII_L, 1, 0, 0, 0);
    addVec("1", 1, 0, 0, 0);
    addVec(":", 0, 0, 0, 1);
    addVec(ASCII_A, 1, 0, 0, 0);
    addVec("/", 0, 0, 0, 1);
    // CR before four digits, and a fifth digit instead of CR
    addVec(ASCII_L, 1, 0, 0, 0);
    addVec("1", 1, 0, 0, 0);
    addVec(ASCII_CR, 0, 0, 0, 1);
    addVec(ASCII_L, 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("5", 0, 0, 0, 1);
    // ESC aborts silently, then stray bytes are ignored
    addVec(ASCII_A, 1, 0, 0, 0);
    addVec("1", 1, 0, 0, 0);
    addVec("2", 1, 0, 0, 0);
    addVec(ASCII_ESC, 1, 0, 0, 0);
    addVec("3", 0, 0, 0, 0);
    addVec(ASCII_CR, 0, 0, 0, 0);
    // Stens limit, ESC in IDLE, then leave alarm enabled before reset
    addVec(ASCII_L, 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("0", 1, 0, 0, 0);
    addVec("6", 0, 0, 0, 1);
    addVec(ASCII_ESC, 0, 0, 0, 0);
    en_exp = 1'b1;
    addVec(ASCII_AT, 1, 0, 0, 0);
    addIdle();
    applyStimulus();

    // reset in the middle of a command
    sendByte(ASCII_L);
    sendByte("1");
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    @(negedge clk12m);
    rst_n = 1'b1;
    t_exp  = 16'h0000;
    a_exp  = 16'h0000;
    en_exp = 1'b0;
    addVec("3", 0, 0, 0, 0);
    addVec("0", 0, 0, 0, 0);
    addVec(ASCII_CR, 0, 0, 0, 0);
    addIdle();
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
